alu_ctrl_fsm: RTL and testbench

//  Multi-cycle control FSM that drives the ALU. Accepts one instruction at a time over a

---
 rtl/alu_ctrl_fsm.sv | 193 +++++++++++++++++++
 tb/tb_alu_ctrl_fsm.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle ALU control FSM: accepts one RV32 instruction at a time, decodes it,
// drives ALUsrc/ALUop/imm and sequences the MEM and WB strobes for the datapath.
module alu_ctrl_fsm #(
  parameter int MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  output logic        ALUsrc,
  output logic [2:0]  ALUop,
  output logic [31:0] imm,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch_taken,
  output logic        done,
  output logic        illegal,
  output logic [2:0]  state
);

  // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
  // instr_ready is high only in IDLE, so instr_valid is ignored while busy.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
  } state_t;

  typedef enum logic [2:0] {K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_ILL} kind_t;

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  state_t         state_q, state_d;
  kind_t          kind_q, kind_d, dec_kind;
  logic [31:0]    instr_q, instr_d;
  logic           alusrc_q, alusrc_d, dec_alusrc;
  logic [2:0]     aluop_q, aluop_d, dec_aluop;
  logic [31:0]    imm_q, imm_d, dec_imm;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];

  always_comb begin
    dec_kind   = K_ILL;
    dec_alusrc = 1'b0;
    dec_aluop  = 3'b000;
    dec_imm    = 32'd0;
    case (opcode)
      7'b0110011: begin
        if (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
          dec_kind  = K_ALU;
          dec_aluop = funct7[5] ? 3'b001 : 3'b000;
        end
      end
      7'b0010011: begin
        if (funct3 == 3'b000) begin
          dec_kind   = K_ALU;
          dec_alusrc = 1'b1;
          dec_imm    = {{20{instr_q[31]}}, instr_q[31:20]};
        end
      end
      7'b0000011: begin
        if (funct3 == 3'b010) begin
          dec_kind   = K_LW;
          dec_alusrc = 1'b1;
          dec_imm    = {{20{instr_q[31]}}, instr_q[31:20]};
        end
      end
      7'b0100011: begin
        if (funct3 == 3'b010) begin
          dec_kind   = K_SW;
          dec_alusrc = 1'b1;
          dec_imm    = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
        end
      end
      7'b1100011: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          dec_kind  = (funct3 == 3'b000) ? K_BEQ : K_BNE;
          dec_aluop = 3'b001;
          dec_imm   = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                       instr_q[30:25], instr_q[11:8], 1'b0};
        end
      end
      default: dec_kind = K_ILL;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    instr_d      = instr_q;
    alusrc_d     = alusrc_q;
    aluop_d      = aluop_q;
    imm_d        = imm_q;
    cnt_d        = cnt_q;
    instr_ready  = 1'b0;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    branch_taken = 1'b0;
    done         = 1'b0;
    illegal      = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_kind == K_ILL) begin
          illegal = 1'b1;
          state_d = S_IDLE;
        end else begin
          kind_d   = dec_kind;
          alusrc_d = dec_alusrc;
          aluop_d  = dec_aluop;
          imm_d    = dec_imm;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        case (kind_q)
          K_BEQ, K_BNE: begin
            // Branch outcome is only meaningful alongside done, so it is not held afterwards.
            branch_taken = (kind_q == K_BEQ) ? alu_zero : ~alu_zero;
            done         = 1'b1;
            state_d      = S_IDLE;
          end
          K_LW, K_SW: begin
            cnt_d   = CW'(MEM_WAIT - 1);
            state_d = S_MEM;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_read  = (kind_q == K_LW);
        mem_write = (kind_q == K_SW);
        if (cnt_q == '0) begin
          if (kind_q == K_LW) begin
            state_d = S_WB;
          end else begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      kind_q   <= K_ALU;
      instr_q  <= 32'd0;
      alusrc_q <= 1'b0;
      aluop_q  <= 3'b000;
      imm_q    <= 32'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      instr_q  <= instr_d;
      alusrc_q <= alusrc_d;
      aluop_q  <= aluop_d;
      imm_q    <= imm_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ALUsrc = alusrc_q;
  assign ALUop  = aluop_q;
  assign imm    = imm_q;
  assign state  = state_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Bench for alu_ctrl_fsm (MEM_WAIT=2): a spec model pushes expected retire records,
// popped and compared when done/illegal fires.
module tb_alu_ctrl_fsm;
  localparam int MW = 2;
  localparam int W  = 51;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = 32'd0;
  logic        alu_zero = 1'b0;
  logic        ALUsrc;
  logic [2:0]  ALUop;
  logic [31:0] imm;
  logic        reg_write, mem_read, mem_write, branch_taken, done, illegal;
  logic [2:0]  state;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int passed = 0;

  alu_ctrl_fsm #(.MEM_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_zero(alu_zero), .ALUsrc(ALUsrc), .ALUop(ALUop), .imm(imm),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch_taken(branch_taken), .done(done), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Record: {ill, lat[3:0], mem_rd_cycles[3:0], mem_wr_cycles[3:0], rw, bt, src, op[2:0], imm[31:0]}
  function automatic logic [W-1:0] model(input logic [31:0] w, input logic z);
    logic ill, rw, bt, src;
    logic [3:0] lat, mrd, mwr;
    logic [2:0] op;
    logic [31:0] im;
    ill = 1'b1; lat = 4'd1; mrd = 4'd0; mwr = 4'd0;
    rw = 1'b0; bt = 1'b0; src = 1'b0; op = 3'b000; im = 32'd0;
    if (w[6:0] == 7'b0110011 && w[14:12] == 3'b000 &&
        (w[31:25] == 7'b0000000 || w[31:25] == 7'b0100000)) begin
      ill = 1'b0; lat = 4'd3; rw = 1'b1; op = w[30] ? 3'b001 : 3'b000;
    end else if (w[6:0] == 7'b0010011 && w[14:12] == 3'b000) begin
      ill = 1'b0; lat = 4'd3; rw = 1'b1; src = 1'b1; im = {{20{w[31]}}, w[31:20]};
    end else if (w[6:0] == 7'b0000011 && w[14:12] == 3'b010) begin
      ill = 1'b0; lat = 4'(3 + MW); rw = 1'b1; src = 1'b1; mrd = 4'(MW);
      im = {{20{w[31]}}, w[31:20]};
    end else if (w[6:0] == 7'b0100011 && w[14:12] == 3'b010) begin
      ill = 1'b0; lat = 4'(2 + MW); src = 1'b1; mwr = 4'(MW);
      im = {{20{w[31]}}, w[31:25], w[11:7]};
    end else if (w[6:0] == 7'b1100011 && (w[14:12] == 3'b000 || w[14:12] == 3'b001)) begin
      ill = 1'b0; lat = 4'd2; op = 3'b001;
      bt = (w[14:12] == 3'b000) ? z : ~z;
      im = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    end
    return {ill, lat, mrd, mwr, rw, bt, src, op, im};
  endfunction

  // Called at a negedge with the FSM in IDLE; returns at the negedge of the cycle after retire.
  task automatic run_instr(input logic [31:0] w, input logic z, input bit hold);
    logic [W-1:0] e;
    int cyc, mrd, mwr, fin, excl_bad;
    exp_q.push_back(model(w, z));
    instr = w; instr_valid = 1'b1; alu_zero = z;
    total++;
    if (instr_ready !== 1'b1) $display("FAIL accept_ready: got %b want 1", instr_ready);
    else passed++;
    @(posedge clk);
    cyc = 0; mrd = 0; mwr = 0; fin = 0; excl_bad = 0;
    while (fin == 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (hold) instr = $urandom;
      else instr_valid = 1'b0;
      mrd += int'(mem_read);
      mwr += int'(mem_write);
      if (int'(mem_read) + int'(mem_write) + int'(reg_write) > 1) excl_bad = 1;
      if (reg_write === 1'b1 && done !== 1'b1) excl_bad = 1;
      if (done === 1'b1 || illegal === 1'b1) begin
        fin = 1;
        e = exp_q.pop_front();
        total++;
        if (cyc !== int'(e[49:46])) $display("FAIL latency w=%h: got %0d want %0d", w, cyc, e[49:46]);
        else passed++;
        total++;
        if (illegal !== e[50] || done !== !e[50])
          $display("FAIL retire_kind w=%h: illegal=%b done=%b want illegal=%b", w, illegal, done, e[50]);
        else passed++;
        total++;
        if (reg_write !== e[37]) $display("FAIL reg_write w=%h: got %b want %b", w, reg_write, e[37]);
        else passed++;
        total++;
        if (branch_taken !== e[36]) $display("FAIL branch_taken w=%h: got %b want %b", w, branch_taken, e[36]);
        else passed++;
        total++;
        if (mrd !== int'(e[45:42])) $display("FAIL mem_read_cycles w=%h: got %0d want %0d", w, mrd, e[45:42]);
        else passed++;
        total++;
        if (mwr !== int'(e[41:38])) $display("FAIL mem_write_cycles w=%h: got %0d want %0d", w, mwr, e[41:38]);
        else passed++;
        if (e[50] == 1'b0) begin
          total++;
          if (ALUsrc !== e[35] || ALUop !== e[34:32] || imm !== e[31:0])
            $display("FAIL alu_ctrl w=%h: src=%b op=%b imm=%h want src=%b op=%b imm=%h",
                     w, ALUsrc, ALUop, imm, e[35], e[34:32], e[31:0]);
          else passed++;
        end
        instr_valid = 1'b0;
      end
    end
    if (fin == 0) begin
      total++;
      $display("FAIL timeout w=%h: no done/illegal in 20 cycles", w);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      instr_valid = 1'b0;
    end
    total++;
    if (excl_bad != 0) $display("FAIL strobe_exclusive w=%h: got overlap want none", w);
    else passed++;
    @(negedge clk);
    total++;
    if (state !== 3'd0 || instr_ready !== 1'b1)
      $display("FAIL idle_after w=%h: state=%0d ready=%b want 0/1", w, state, instr_ready);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (state !== 3'd0 || instr_ready !== 1'b1 || reg_write !== 1'b0 || mem_read !== 1'b0 ||
        mem_write !== 1'b0 || branch_taken !== 1'b0 || done !== 1'b0 || illegal !== 1'b0 ||
        ALUsrc !== 1'b0 || ALUop !== 3'b000 || imm !== 32'd0)
      $display("FAIL reset_state: state=%0d ready=%b rw=%b mr=%b mw=%b bt=%b d=%b il=%b src=%b op=%b imm=%h",
               state, instr_ready, reg_write, mem_read, mem_write, branch_taken, done, illegal,
               ALUsrc, ALUop, imm);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    run_instr(32'h002081B3, 1'b0, 1'b0);  // add x3,x1,x2
    run_instr(32'h402081B3, 1'b1, 1'b0);  // sub x3,x1,x2
    run_instr(32'hFFF00293, 1'b0, 1'b0);  // addi x5,x0,-1
  endtask

  task automatic test_mem();
    run_instr(32'h0020A423, 1'b0, 1'b0);  // sw x2,8(x1)
    run_instr(32'h0080A183, 1'b0, 1'b1);  // lw x3,8(x1), valid held while busy
  endtask

  task automatic test_branch();
    run_instr(32'hFE208EE3, 1'b1, 1'b0);  // beq x1,x2,-4 taken
    run_instr(32'hFE208EE3, 1'b0, 1'b0);  // beq not taken
    run_instr(32'hFE209EE3, 1'b0, 1'b0);  // bne taken
    run_instr(32'hFE209EE3, 1'b1, 1'b0);  // bne not taken
  endtask

  task automatic test_illegal();
    run_instr(32'h00000000, 1'b0, 1'b1);  // valid held through the illegal drop
    run_instr(32'h022081B3, 1'b0, 1'b0);  // R-type with bad funct7
    run_instr(32'h00008183, 1'b0, 1'b0);  // load with funct3 000
    run_instr(32'hFE20AEE3, 1'b0, 1'b0);  // branch funct3 010
  endtask

  task automatic test_reset_mid();
    int bad;
    instr = 32'h0080A183; instr_valid = 1'b1; alu_zero = 1'b0;
    @(posedge clk);
    @(negedge clk); instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (state !== 3'd3) $display("FAIL mid_in_mem: state=%0d want 3", state);
    else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (state !== 3'd0 || mem_read !== 1'b0 || done !== 1'b0)
      $display("FAIL mid_reset_idle: state=%0d mr=%b done=%b want 0/0/0", state, mem_read, done);
    else passed++;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_read || reg_write || done || state !== 3'd0) bad = 1;
    end
    total++;
    if (bad != 0) $display("FAIL mid_reset_quiet: got activity want none");
    else passed++;
    run_instr(32'h0080A183, 1'b0, 1'b0);  // counter must start fresh
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    int k;
    for (int i = 0; i < 14; i++) begin
      w = $urandom;
      k = $urandom_range(0, 6);
      case (k)
        0: begin w[6:0] = 7'b0110011; w[14:12] = 3'b000; w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
        1: begin w[6:0] = 7'b0010011; w[14:12] = 3'b000; end
        2: begin w[6:0] = 7'b0000011; w[14:12] = 3'b010; end
        3: begin w[6:0] = 7'b0100011; w[14:12] = 3'b010; end
        4: begin w[6:0] = 7'b1100011; w[14:12] = 3'b000; end
        5: begin w[6:0] = 7'b1100011; w[14:12] = 3'b001; end
        default: begin w[6:0] = 7'b1110011; end
      endcase
      run_instr(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
